// File: rtl/sample_fifo.sv
// Synchronous first-word-fall-through sample FIFO with full/almost-full flags and occupancy.
// Optional sticky overflow/underflow flags are enabled by defining SAMPLE_FIFO_ERR_EN.
module sample_fifo #(
  parameter int NBITS    = 8,
  parameter int PTBITS   = 4,
  parameter int AFULL_TH = 12
) (
  input  logic              ck,
  input  logic              rst,
  input  logic [NBITS-1:0]  in,
  input  logic              ld,
  input  logic              pp,
  input  logic              flush,
  output logic [NBITS-1:0]  out,
  output logic              em,
  output logic              fl,
  output logic              afl,
  output logic [PTBITS:0]   cnt,
  output logic              ovf,
  output logic              udf
);
  localparam int SIZE = 2 ** PTBITS;
  localparam logic [PTBITS:0] CNT_FULL = (PTBITS+1)'(SIZE);
  localparam logic [PTBITS:0] CNT_AFL  = (PTBITS+1)'(AFULL_TH);

  // Handshake: em low means `out` holds a valid head word; the consumer takes it by
  // raising pp in that cycle. ld is a push request, accepted unless full without a pop.

  logic [NBITS-1:0]  mem_q [SIZE];
  logic [PTBITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTBITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTBITS-1:0] rd_next;
  logic [PTBITS:0]   cnt_q, cnt_d;
  logic [NBITS-1:0]  out_q, out_d;
  logic              pop_ok, push_ok, wr_en;

  always_comb begin
    pop_ok   = pp && (cnt_q != '0);
    push_ok  = ld && ((cnt_q != CNT_FULL) || pop_ok);
    rd_next  = rd_ptr_q + 1'b1;
    wr_en    = 1'b0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      out_d    = '0;
    end else begin
      if (push_ok) begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_d = rd_next;
      end
      if (push_ok && !pop_ok) begin
        cnt_d = cnt_q + 1'b1;
      end else if (pop_ok && !push_ok) begin
        cnt_d = cnt_q - 1'b1;
      end
      // Head update: next stored word, or the incoming word when it becomes the head.
      if (pop_ok && (cnt_q > (PTBITS+1)'(1))) begin
        out_d = mem_q[rd_next];
      end else if (push_ok && ((cnt_q == '0) || pop_ok)) begin
        out_d = in;
      end
    end
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
    end
  end

  // Storage has no reset; a write is suppressed on reset and flush edges.
  always_ff @(posedge ck) begin
    if (!rst && wr_en) begin
      mem_q[wr_ptr_q] <= in;
    end
  end

`ifdef SAMPLE_FIFO_ERR_EN
  logic ovf_q, ovf_d, udf_q, udf_d;

  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (flush) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end else begin
      if (ld && !push_ok) ovf_d = 1'b1;
      if (pp && (cnt_q == '0)) udf_d = 1'b1;
    end
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign ovf = ovf_q;
  assign udf = udf_q;
`else
  assign ovf = 1'b0;
  assign udf = 1'b0;
`endif

  assign out = out_q;
  assign cnt = cnt_q;
  assign em  = (cnt_q == '0);
  assign fl  = (cnt_q == CNT_FULL);
  assign afl = (cnt_q >= CNT_AFL);
endmodule
